debug_cmd_parser: RTL

// Decodes the host debug protocol from the UART receiver's byte stream and drives CPU run control.

---
 rtl/debug_cmd_parser.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/debug_cmd_parser.sv
// Host debug protocol decoder: turns UART bytes into CPU run control,
// breakpoint arming, program-load forwarding and a PING/OK reply.
module debug_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned PROG_MAX_WORDS = 16384,
    parameter bit          START_PAUSED   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        cpu_pause,
    output logic        step,
    output logic [31:0] bp_addr,
    output logic        bp_valid,
    output logic        bp_hit,
    output logic        prog_active,
    output logic [7:0]  prog_byte,
    output logic        prog_byte_valid,
    output logic        prog_done,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(PROG_MAX_WORDS * 4 + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARG, S_PROG, S_SEND_OK} state_t;

    state_t        state_q, state_d;
    logic [23:0]   arg_q, arg_d;
    logic [1:0]    nb_q, nb_d;
    logic          is_prog_q, is_prog_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          pause_q, pause_d;
    logic          step_q, step_d;
    logic [31:0]   bpa_q, bpa_d;
    logic          bpv_q, bpv_d;
    logic          hit_q, hit_d;
    logic          pact_q, pact_d;
    logic [7:0]    pbyte_q, pbyte_d;
    logic          pbv_q, pbv_d;
    logic          pdone_q, pdone_d;
    logic          err_q, err_d;
    logic [7:0]    txd_q, txd_d;
    logic          txv_q, txv_d;

    logic [31:0] arg_full;
    logic        timeout;
    logic        cmd_upd;

    assign arg_full = {rx_data, arg_q};
    assign timeout  = (state_q == S_ARG || state_q == S_PROG) && !rx_valid
                      && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Next-state: command decoding first, breakpoint match only if no command acted.
    always_comb begin
        state_d   = state_q;
        arg_d     = arg_q;
        nb_d      = nb_q;
        is_prog_d = is_prog_q;
        rem_d     = rem_q;
        pause_d   = pause_q;
        bpa_d     = bpa_q;
        bpv_d     = bpv_q;
        pact_d    = pact_q;
        pbyte_d   = pbyte_q;
        txd_d     = txd_q;
        txv_d     = txv_q;
        step_d    = 1'b0;
        hit_d     = 1'b0;
        pbv_d     = 1'b0;
        pdone_d   = 1'b0;
        err_d     = 1'b0;
        cmd_upd   = 1'b0;
        tmo_d     = '0;
        if ((state_q == S_ARG || state_q == S_PROG) && !rx_valid)
            tmo_d = tmo_q + TW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h03: begin
                            state_d = S_SEND_OK;
                            txv_d   = 1'b1;
                            txd_d   = 8'h02;
                        end
                        8'h04: begin
                            pause_d = 1'b1;
                            cmd_upd = 1'b1;
                        end
                        8'h05, 8'h07: begin
                            state_d   = S_ARG;
                            is_prog_d = (rx_data == 8'h07);
                            nb_d      = '0;
                        end
                        8'h06: step_d = pause_q;
                        8'hFF: begin
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_ARG: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    tmo_d   = '0;
                end else if (rx_valid) begin
                    arg_d = {rx_data, arg_q[23:8]};
                    nb_d  = nb_q + 2'd1;
                    if (nb_q == 2'd3) begin
                        state_d = S_IDLE;
                        cmd_upd = 1'b1;
                        if (!is_prog_q) begin
                            bpa_d   = arg_full;
                            bpv_d   = (arg_full != 32'd0);
                            pause_d = 1'b0;
                        end else if (arg_full == 32'd0) begin
                            pdone_d = 1'b1;
                        end else if (arg_full > 32'(PROG_MAX_WORDS)) begin
                            err_d = 1'b1;
                        end else begin
                            rem_d   = RW'({arg_full[29:0], 2'b00});
                            pact_d  = 1'b1;
                            pause_d = 1'b1;
                            state_d = S_PROG;
                        end
                    end
                end
            end
            S_PROG: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    pact_d  = 1'b0;
                    state_d = S_IDLE;
                    tmo_d   = '0;
                end else if (rx_valid) begin
                    pbyte_d = rx_data;
                    pbv_d   = 1'b1;
                    rem_d   = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        pdone_d = 1'b1;
                        pact_d  = 1'b0;
                        bpv_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_SEND_OK: begin
                err_d = rx_valid;
                if (tx_ready) begin
                    txv_d   = 1'b0;
                    txd_d   = 8'h00;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!cmd_upd && !pause_q && bpv_q && pc_valid && pc == bpa_q) begin
            pause_d = 1'b1;
            bpv_d   = 1'b0;
            hit_d   = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            arg_q     <= '0;
            nb_q      <= '0;
            is_prog_q <= 1'b0;
            tmo_q     <= '0;
            rem_q     <= '0;
            pause_q   <= START_PAUSED;
            step_q    <= 1'b0;
            bpa_q     <= '0;
            bpv_q     <= 1'b0;
            hit_q     <= 1'b0;
            pact_q    <= 1'b0;
            pbyte_q   <= '0;
            pbv_q     <= 1'b0;
            pdone_q   <= 1'b0;
            err_q     <= 1'b0;
            txd_q     <= '0;
            txv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arg_q     <= arg_d;
            nb_q      <= nb_d;
            is_prog_q <= is_prog_d;
            tmo_q     <= tmo_d;
            rem_q     <= rem_d;
            pause_q   <= pause_d;
            step_q    <= step_d;
            bpa_q     <= bpa_d;
            bpv_q     <= bpv_d;
            hit_q     <= hit_d;
            pact_q    <= pact_d;
            pbyte_q   <= pbyte_d;
            pbv_q     <= pbv_d;
            pdone_q   <= pdone_d;
            err_q     <= err_d;
            txd_q     <= txd_d;
            txv_q     <= txv_d;
        end
    end

    assign tx_data         = txd_q;
    assign tx_valid        = txv_q;
    assign cpu_pause       = pause_q;
    assign step            = step_q;
    assign bp_addr         = bpa_q;
    assign bp_valid        = bpv_q;
    assign bp_hit          = hit_q;
    assign prog_active     = pact_q;
    assign prog_byte       = pbyte_q;
    assign prog_byte_valid = pbv_q;
    assign prog_done       = pdone_q;
    assign err             = err_q;

endmodule
